// File: rtl/fir_decimator.sv
// Decimating accumulator behind a FIR: sums DECIM samples, rounds, shifts and queues
// 16-bit results in a small FIFO. Define FIR_DECIM_SAT_EN to clamp instead of wrap.
module fir_decimator #(
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample,
  input  logic signed [31:0] in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_data,
  output logic               overflow
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_PHASE = CW'(DECIM - 1);
  // Half an output LSB; evaluates to zero when SHIFT is zero.
  localparam logic signed [47:0] ROUND = (48'sd1 <<< SHIFT) >>> 1;

  logic signed [47:0] acc;
  logic signed [47:0] in_ext;
  logic signed [47:0] sum;
  logic signed [47:0] shifted;
  logic [CW-1:0]      phase;
  logic               last_sample;
  logic signed [15:0] result;
  logic               push_pend;
  logic signed [15:0] push_data;

  assign in_ext      = {{16{in[31]}}, in};
  assign last_sample = sample && (phase == LAST_PHASE);
  assign sum         = acc + in_ext + ROUND;
  assign shifted     = sum >>> SHIFT;

`ifdef FIR_DECIM_SAT_EN
  // NOTE: result gets a value before any condition so no latch is inferred.
  always_comb begin
    result = shifted[15:0];
    if (shifted > 48'sd32767)
      result = 16'sh7FFF;
    else if (shifted < -48'sd32768)
      result = 16'sh8000;
  end
`else
  logic unused_high;
  assign result      = shifted[15:0];
  assign unused_high = ^shifted[47:16];
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      phase     <= '0;
      push_pend <= 1'b0;
      push_data <= '0;
    end else begin
      push_pend <= last_sample;
      if (last_sample)
        push_data <= result;
      if (sample) begin
        if (last_sample) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= acc + in_ext;
          phase <= phase + 1'b1;
        end
      end
    end
  end

  // Output FIFO: pointers carry one extra wrap bit so full and empty differ.
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic signed [15:0] mem [DEPTH];
  logic               empty;
  logic               full;
  logic               pop;
  logic               do_write;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && out_ready;
  assign do_write = push_pend && (!full || pop);

  // NOTE: storage is not reset; empty pointers gate every read, so old contents are never seen.
  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_pend && full && !pop)
        overflow <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? 16'sd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 SHALL have parameter DECIM, default 4, meaning filter samples summed per output word (2..256).
REQ-002 SHALL have parameter SHIFT, default 2, meaning arithmetic right shift applied to the sum (0..16).
REQ-003 SHALL have parameter DEPTH, default 4, meaning output FIFO entries (power of two, 2..16).
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 sample  input  1  strobe marking in as valid this cycle (same strobe that advances the upstream FIR).
REQ-007 in  input  32  signed filter output word.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_data  output  16  signed decimated word at FIFO head.
REQ-011 overflow  output  1  sticky flag: a result was dropped because the FIFO was full.

Function
REQ-012 Accumulator SHALL be 48-bit signed; each cycle with sample=1 adds sign-extended in.
REQ-013 Phase counter SHALL count 0..DECIM-1, advancing only on sample=1, wrapping to 0 after DECIM-1.
REQ-014 On the sample with counter=DECIM-1, result = (acc + in + round) >>> SHIFT, round = 2^(SHIFT-1) when SHIFT>0, else 0; accumulator SHALL clear to 0 the same edge (dump, no carry-over).
REQ-015 Result SHALL be pushed into the FIFO on the edge after that sample (latency: one clock from final sample to FIFO write, out_valid visible the following cycle if previously empty).
REQ-016 sample=0 cycles SHALL leave accumulator and counter unchanged.
REQ-017 Pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-018 Push and pop in the same cycle SHALL both take effect, including when FIFO is full (occupancy unchanged, no overflow).
REQ-019 Push when full without simultaneous pop SHALL drop the result and set overflow; overflow clears only on reset.
REQ-020 Pop when empty SHALL be ignored; out_data SHALL read 0 when empty.
REQ-021 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy tracked with one extra bit to distinguish full from empty.

Reset
REQ-022 rst=1 SHALL immediately clear accumulator, phase counter, pending-push register, FIFO pointers and overflow, regardless of clk.
REQ-023 During and after reset: out_valid=0, out_data=0, overflow=0.
REQ-024 Reset mid-accumulation SHALL discard the partial sum; the first sample after release is phase 0.
REQ-025 Reset deassertion SHALL take effect on the next clk edge with no further wait cycles.

Configuration
REQ-026 Macro FIR_DECIM_SAT_EN defined: shifted result outside [-32768, 32767] SHALL clamp to the nearest bound.
REQ-027 FIR_DECIM_SAT_EN undefined: out_data SHALL be bits [15:0] of the shifted result (two's-complement wrap); no saturation logic synthesized.

Verification
REQ-028 DECIM=4, SHIFT=2; in=1,2,3,4 on four sample strobes -> one push, out_data=3 ((10+2)>>>2).
REQ-029 in=-5 four times -> out_data=-5 ((-20+2)>>>2 = -18>>>2); sample gaps of 3 idle cycles between strobes give identical result.
REQ-030 in=0x40000000 four times -> out_data=32767 with FIR_DECIM_SAT_EN, out_data=0 without.
REQ-031 out_ready=0, five full decimation frames (in=1,2,3,4 each) -> four entries held, overflow=1; then out_ready=1 -> four pops of 3, out_valid falls after fourth.
REQ-032 FIFO full, push and pop same cycle -> occupancy stays 4, overflow stays 0.
REQ-033 rst pulsed after two samples of 100 -> outputs 0; next frame 1,2,3,4 -> out_data=3.
